// File: rtl/eth_pkg.sv
// Shared constants and FSM state encoding for the Ethernet TX FCS inserter.
package eth_pkg;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam int unsigned ETH_MIN_BYTES = 60;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2
    } state_t;

endpackage

// File: rtl/crc32.sv
// Combinational reflected CRC-32 update over one WIDTH-bit beat, bit 0 consumed first.
module crc32
    import eth_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter logic [31:0] CRC_POLY = eth_pkg::CRC_POLY
) (
    input  logic [WIDTH-1:0] din,
    input  logic [31:0]      crc_cur,
    output logic [31:0]      crc_next
);

    always_comb begin
        crc_next = crc_cur;
        for (int i = 0; i < int'(WIDTH); i++) begin
            crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ din[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_fcs_inserter.sv
// Streaming Ethernet TX FCS controller: passes frame beats, zero-pads short frames,
// then appends the inverted CRC-32 LSB-first.
module eth_fcs_inserter #(
    parameter int unsigned DW        = 4,
    parameter int unsigned MIN_BYTES = eth_pkg::ETH_MIN_BYTES,
    parameter bit          PAD_EN    = 1'b1,
    parameter logic [31:0] CRC_POLY  = eth_pkg::CRC_POLY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          frame_done
);
    import eth_pkg::*;

    localparam int unsigned MIN_BEATS = MIN_BYTES * 8 / DW;
    localparam int unsigned FCS_BEATS = 32 / DW;
    localparam int unsigned CNT_W     = $clog2(MIN_BEATS + 1);
    localparam int unsigned IDX_W     = $clog2(FCS_BEATS);

    state_t           state, state_next;
    logic [31:0]      crc_q, crc_d, crc_upd, crc_inv;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_d, cnt_sat;
    logic [CNT_W:0]   cnt_inc;
    logic [IDX_W-1:0] fcs_idx, fcs_idx_d;
    logic [DW-1:0]    crc_din;
    logic             done_d;
    logic             xfer;

    // Pad beats feed zeros into the CRC regardless of what upstream presents.
    assign crc_din = (state == PAD) ? '0 : s_data;

    crc32 #(
        .WIDTH    (DW),
        .CRC_POLY (CRC_POLY)
    ) u_crc32 (
        .din      (crc_din),
        .crc_cur  (crc_q),
        .crc_next (crc_upd)
    );

    // Count including the beat being transferred now, widened so saturation can't wrap it.
    assign cnt_inc = (CNT_W + 1)'(beat_cnt) + (CNT_W + 1)'(1);
    assign cnt_sat = (beat_cnt == CNT_W'(MIN_BEATS)) ? beat_cnt : beat_cnt + CNT_W'(1);
    assign crc_inv = ~crc_q;

    always_comb begin
        state_next = state;
        crc_d      = crc_q;
        beat_cnt_d = beat_cnt;
        fcs_idx_d  = fcs_idx;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;

        case (state)
            DATA: begin
                m_data  = s_data;
                m_valid = s_valid;
                s_ready = m_ready;
            end
            PAD: begin
                m_valid = 1'b1;
            end
            FCS: begin
                m_valid = 1'b1;
                m_data  = crc_inv[32'(fcs_idx) * DW +: DW];
                m_last  = (fcs_idx == IDX_W'(FCS_BEATS - 1));
            end
            default: ;
        endcase

        if (rst) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
        end

        xfer = m_valid & m_ready;

        if (xfer) begin
            case (state)
                DATA: begin
                    crc_d      = crc_upd;
                    beat_cnt_d = cnt_sat;
                    if (s_last) begin
                        state_next = (PAD_EN && (cnt_inc < (CNT_W + 1)'(MIN_BEATS))) ? PAD : FCS;
                    end
                end
                PAD: begin
                    crc_d      = crc_upd;
                    beat_cnt_d = cnt_sat;
                    if (cnt_inc == (CNT_W + 1)'(MIN_BEATS)) begin
                        state_next = FCS;
                    end
                end
                FCS: begin
                    if (m_last) begin
                        state_next = DATA;
                        crc_d      = CRC_INIT;
                        beat_cnt_d = '0;
                        fcs_idx_d  = '0;
                        done_d     = 1'b1;
                    end else begin
                        fcs_idx_d = fcs_idx + IDX_W'(1);
                    end
                end
                default: state_next = DATA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DATA;
            crc_q      <= CRC_INIT;
            beat_cnt   <= '0;
            fcs_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            crc_q      <= crc_d;
            beat_cnt   <= beat_cnt_d;
            fcs_idx    <= fcs_idx_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Directed self-checking bench for eth_fcs_inserter across DW=2/4/8 and PAD_EN=0/1.
module tb_eth_fcs_inserter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic [7:0] s_data;
    logic       s_valid, s_last, m_ready;

    wire [3:0] sv, sr, mv, ml, fd;
    wire [3:0] md_a, md_b;
    wire [1:0] md_c;
    wire [7:0] md_d;

    logic [7:0] mdm;
    logic       srm, mvm, mlm, fdm;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ref_q[$];
    int         got_last_idx;
    int         sready_bad, stable_bad, done_bad, idle_bad, timeouts;
    logic       done_pending;

    always #5 clk = ~clk;

    assign sv = {s_valid && sel == 2'd3, s_valid && sel == 2'd2,
                 s_valid && sel == 2'd1, s_valid && sel == 2'd0};

    always_comb begin
        case (sel)
            2'd0:    mdm = {4'b0, md_a};
            2'd1:    mdm = {4'b0, md_b};
            2'd2:    mdm = {6'b0, md_c};
            default: mdm = md_d;
        endcase
        srm = sr[sel];
        mvm = mv[sel];
        mlm = ml[sel];
        fdm = fd[sel];
    end

    eth_fcs_inserter #(.DW(4), .PAD_EN(1'b0)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data[3:0]), .s_valid(sv[0]), .s_last(s_last),
        .s_ready(sr[0]), .m_data(md_a), .m_valid(mv[0]), .m_last(ml[0]), .m_ready(m_ready),
        .frame_done(fd[0]));

    eth_fcs_inserter #(.DW(4), .PAD_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data[3:0]), .s_valid(sv[1]), .s_last(s_last),
        .s_ready(sr[1]), .m_data(md_b), .m_valid(mv[1]), .m_last(ml[1]), .m_ready(m_ready),
        .frame_done(fd[1]));

    eth_fcs_inserter #(.DW(2), .PAD_EN(1'b1)) dut_c (
        .clk(clk), .rst(rst), .s_data(s_data[1:0]), .s_valid(sv[2]), .s_last(s_last),
        .s_ready(sr[2]), .m_data(md_c), .m_valid(mv[2]), .m_last(ml[2]), .m_ready(m_ready),
        .frame_done(fd[2]));

    eth_fcs_inserter #(.DW(8), .PAD_EN(1'b1)) dut_d (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(sv[3]), .s_last(s_last),
        .s_ready(sr[3]), .m_data(md_d), .m_valid(mv[3]), .m_last(ml[3]), .m_ready(m_ready),
        .frame_done(fd[3]));

    // Byte-wise reference CRC; returns the value as transmitted (already inverted).
    function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'b0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void build_exp(input logic [7:0] bytes[$], input int dw, input bit pad_en);
        logic [7:0]  fb[$];
        logic [31:0] fcs;
        fb = bytes;
        if (pad_en) while (fb.size() < 60) fb.push_back(8'h00);
        fcs = fcs_of(fb);
        exp_q.delete();
        foreach (fb[i])
            for (int k = 0; k < 8 / dw; k++)
                exp_q.push_back(8'((fb[i] >> (k * dw)) & ((1 << dw) - 1)));
        for (int i = 0; i < 32 / dw; i++)
            exp_q.push_back(8'((fcs >> (i * dw)) & ((1 << dw) - 1)));
    endfunction

    function automatic int stream_diffs(input logic [7:0] a[$], input logic [7:0] b[$]);
        int d = 0;
        if (a.size() != b.size()) d++;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) d++;
        return d;
    endfunction

    function automatic void clear_counters();
        sready_bad = 0; stable_bad = 0; done_bad = 0; idle_bad = 0; timeouts = 0;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
            @(negedge clk);
            if (fdm !== done_pending) done_bad++;
            done_pending = 1'b0;
            if (mvm !== 1'b0) idle_bad++;
        end
    endtask

    // Drives one frame on the selected DUT and collects every accepted output beat.
    task automatic send_frame(input logic [7:0] bytes[$], input int dw, input int stall_pct);
        logic [7:0] beats[$];
        int         idx = 0;
        int         cyc = 0;
        bit         seen_last = 1'b0;
        logic       prev_hold = 1'b0;
        logic [7:0] prev_md = '0;
        foreach (bytes[i])
            for (int k = 0; k < 8 / dw; k++)
                beats.push_back(8'((bytes[i] >> (k * dw)) & ((1 << dw) - 1)));
        got_q.delete();
        got_last_idx = -1;
        while (!seen_last && cyc < 3000) begin
            @(posedge clk); #1;
            m_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            if (idx < beats.size()) begin
                s_valid = 1'b1; s_data = beats[idx]; s_last = (idx == beats.size() - 1);
            end else begin
                s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (fdm !== done_pending) done_bad++;
            done_pending = 1'b0;
            if (idx == beats.size() && srm !== 1'b0) sready_bad++;
            if (prev_hold && mdm !== prev_md) stable_bad++;
            prev_hold = mvm && !m_ready;
            prev_md   = mdm;
            if (s_valid && srm) idx++;
            if (mvm && m_ready) begin
                got_q.push_back(mdm);
                if (mlm) begin
                    seen_last    = 1'b1;
                    got_last_idx = got_q.size() - 1;
                    done_pending = 1'b1;
                end
            end
        end
        if (!seen_last) timeouts++;
    endtask

    task automatic test_reset();
        sel = 2'd1;
        rst = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = 8'h5; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (srm !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b want 0", srm); end
        tests++; if (mvm !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", mvm); end
        tests++; if (mlm !== 1'b0) begin fails++; $display("FAIL reset_m_last: got %b want 0", mlm); end
        tests++; if (fdm !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", fdm); end
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        done_pending = 1'b0;
        idle(2);
    endtask

    task automatic test_check_value();
        logic [7:0] bytes[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        logic [3:0] hand[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        int         hbad = 0;
        sel = 2'd0;
        clear_counters();
        send_frame(bytes, 4, 0);
        idle(2);
        build_exp(bytes, 4, 1'b0);
        tests++; if (got_q.size() !== 26) begin fails++; $display("FAIL t1_len: got %0d want 26", got_q.size()); end
        for (int i = 0; i < 8 && 18 + i < got_q.size(); i++)
            if (got_q[18 + i] !== {4'b0, hand[i]}) hbad++;
        tests++; if (hbad !== 0 || got_q.size() < 26) begin fails++; $display("FAIL t1_fcs_nibbles: %0d wrong want 0", hbad); end
        tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t1_stream: %0d diffs want 0", stream_diffs(got_q, exp_q)); end
        tests++; if (got_last_idx !== 25) begin fails++; $display("FAIL t1_m_last_pos: got %0d want 25", got_last_idx); end
        tests++; if (done_bad + timeouts + sready_bad !== 0) begin fails++; $display("FAIL t1_done_ready: done=%0d to=%0d rdy=%0d want 0", done_bad, timeouts, sready_bad); end
    endtask

    task automatic test_pad();
        logic [7:0] bytes[$] = '{8'h00};
        sel = 2'd1;
        clear_counters();
        send_frame(bytes, 4, 0);
        idle(2);
        build_exp(bytes, 4, 1'b1);
        tests++; if (got_q.size() !== 128) begin fails++; $display("FAIL t2_len: got %0d want 128", got_q.size()); end
        tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t2_stream: %0d diffs want 0", stream_diffs(got_q, exp_q)); end
        tests++; if (got_last_idx !== 127) begin fails++; $display("FAIL t2_m_last_pos: got %0d want 127", got_last_idx); end
        tests++; if (sready_bad !== 0) begin fails++; $display("FAIL t2_s_ready_pad: %0d cycles high want 0", sready_bad); end
        tests++; if (done_bad + timeouts !== 0) begin fails++; $display("FAIL t2_done: done=%0d to=%0d want 0", done_bad, timeouts); end
    endtask

    task automatic test_min_frames();
        logic [7:0] bytes[$];
        for (int len = 60; len <= 61; len++) begin
            bytes.delete();
            for (int i = 0; i < len; i++) bytes.push_back(8'(i * 7 + 3));
            sel = 2'd1;
            clear_counters();
            send_frame(bytes, 4, 0);
            idle(2);
            build_exp(bytes, 4, 1'b1);
            tests++; if (got_q.size() !== len * 2 + 8) begin fails++; $display("FAIL t3_len%0d: got %0d want %0d", len, got_q.size(), len * 2 + 8); end
            tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t3_stream%0d: %0d diffs want 0", len, stream_diffs(got_q, exp_q)); end
            tests++; if (sready_bad + done_bad + timeouts !== 0) begin fails++; $display("FAIL t3_ctrl%0d: rdy=%0d done=%0d to=%0d want 0", len, sready_bad, done_bad, timeouts); end
        end
    endtask

    task automatic test_stalls();
        logic [7:0] bytes[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        sel = 2'd1;
        clear_counters();
        send_frame(bytes, 4, 0);
        idle(2);
        ref_q = got_q;
        send_frame(bytes, 4, 50);
        idle(2);
        build_exp(bytes, 4, 1'b1);
        tests++; if (stream_diffs(got_q, ref_q) !== 0) begin fails++; $display("FAIL t4_vs_nostall: %0d diffs want 0", stream_diffs(got_q, ref_q)); end
        tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t4_vs_model: %0d diffs want 0", stream_diffs(got_q, exp_q)); end
        tests++; if (stable_bad !== 0) begin fails++; $display("FAIL t4_hold_stable: %0d changes want 0", stable_bad); end
        tests++; if (sready_bad + done_bad + timeouts !== 0) begin fails++; $display("FAIL t4_ctrl: rdy=%0d done=%0d to=%0d want 0", sready_bad, done_bad, timeouts); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes[$] = '{8'h11, 8'h22, 8'h33};
        sel = 2'd1;
        clear_counters();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1; s_data = (i == 0) ? 8'hA : 8'h5; s_last = (i == 1); m_ready = 1'b1;
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        tests++; if (mvm !== 1'b1 || mdm !== 8'h0 || srm !== 1'b0) begin fails++; $display("FAIL t5_in_pad: valid=%b data=%h ready=%b want 1 00 0", mvm, mdm, srm); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (mvm !== 1'b0 || srm !== 1'b0) begin fails++; $display("FAIL t5_rst_outputs: valid=%b ready=%b want 0 0", mvm, srm); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        tests++; if (idle_bad + done_bad !== 0) begin fails++; $display("FAIL t5_no_fcs: valid_beats=%0d done=%0d want 0", idle_bad, done_bad); end
        send_frame(bytes, 4, 0);
        idle(2);
        build_exp(bytes, 4, 1'b1);
        tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t5_frame_b: %0d diffs want 0", stream_diffs(got_q, exp_q)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa[$];
        logic [7:0] fb[$];
        for (int w = 0; w < 2; w++) begin
            int dw = (w == 0) ? 2 : 8;
            sel = (w == 0) ? 2'd2 : 2'd3;
            fa.delete(); fb.delete();
            for (int i = 0; i < 61; i++) fa.push_back(8'($urandom));
            for (int i = 0; i < 10; i++) fb.push_back(8'($urandom));
            clear_counters();
            send_frame(fa, dw, 0);
            build_exp(fa, dw, 1'b1);
            tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t6_dw%0d_a: %0d diffs want 0", dw, stream_diffs(got_q, exp_q)); end
            send_frame(fb, dw, 0);
            build_exp(fb, dw, 1'b1);
            tests++; if (stream_diffs(got_q, exp_q) !== 0) begin fails++; $display("FAIL t6_dw%0d_b: %0d diffs want 0", dw, stream_diffs(got_q, exp_q)); end
            idle(2);
            tests++; if (sready_bad + done_bad + timeouts !== 0) begin fails++; $display("FAIL t6_dw%0d_ctrl: rdy=%0d done=%0d to=%0d want 0", dw, sready_bad, done_bad, timeouts); end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 2'd0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        done_pending = 1'b0;
        clear_counters();
        test_reset();
        test_check_value();
        test_pad();
        test_min_frames();
        test_stalls();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
